ssd1309_spi_receiver: RTL and testbench
=======================================

# ssd1309_spi_receiver

Receive-side model of the SSD1309 4-wire SPI link: oversamples SCLK/SDIN/DC/CS on the system clock, assembles MSB-first bytes, decodes the page-addressing command subset and turns pixel data bytes into framebuffer write transactions. It sits opposite the OLED driver's SPI output, used as a loopback/display emulator, and feeds a monochrome framebuffer write port with the same we / w_data_valid handshake the design already uses for framebuffer writes.

## Interface

- SYNC_STAGES, 2, flip-flops per input synchronizer (≥2)
- COLS, 128, display width in columns; column pointer wraps at COLS-1
- PAGES, 8, number of 8-row pages; page commands outside 0..PAGES-1 are ignored

- clk  in  1  system clock (27 MHz)
- rst_n  in  1  synchronous active-low reset
- spi_sclk  in  1  SPI clock, async; SDIN sampled on rising edge
- spi_sdin  in  1  SPI data, MSB first, async
- spi_dc  in  1  0 = command byte, 1 = pixel data byte, async
- spi_cs_n  in  1  chip select, active low, async
- oled_res_n  in  1  display reset, active low, async
- fb_we  out  1  framebuffer write request
- fb_w_xpos  out  8  column of the write
- fb_w_ypos  out  8  top pixel row of the write = page*8
- fb_din  out  8  vertical 8-pixel strip, bit 0 = row fb_w_ypos
- fb_w_data_valid  in  1  framebuffer write acknowledge
- cmd_valid  out  1  one-cycle strobe per received command byte
- cmd_byte  out  8  last command byte, valid with cmd_valid
- display_on  out  1  1 after 0xAF, 0 after 0xAE
- overflow_err  out  1  sticky: pixel byte dropped

## Operation

- All four SPI inputs and oled_res_n pass through SYNC_STAGES-deep synchronizers; SCLK rising edge detected on synchronized copies; SDIN/DC taken from the same synchronized sample slot.
- Requires SCLK high and low phases ≥ 2 clk each (SCLK ≤ clk/4).
- Bit counter 0..7 advances only while synced cs_n = 0; cs_n high clears bit counter and shift register (partial byte discarded, no output).
- On 8th bit: byte and DC latched. DC=0 → command path, DC=1 → data path.
- Command path (cmd_valid pulses for every command byte, including arguments):
  - Argument skip counter > 0: decrement, no decode.
  - 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0xFD: load skip = 1.
  - 0x21, 0x22: load skip = 2.
  - 0x00–0x0F: col[3:0] = byte[3:0]. 0x10–0x17: col[6:4] = byte[2:0].
  - 0xB0–0xB7: page = byte[2:0] (if < PAGES).
  - 0xAE / 0xAF: display_on = 0 / 1. All others: no state change.
- Data path: emit write {x=col, y=page*8, din=byte}; col increments, COLS-1 wraps to 0, page unchanged (page addressing only; 0x20 mode argument ignored).
- Write FSM: W_IDLE → W_REQ (fb_we=1, x/y/din stable) → on fb_w_data_valid=1, fb_we=0, go W_DRAIN → W_IDLE once fb_w_data_valid=0. New request never asserted while fb_w_data_valid is high.
- One-entry skid buffer holds a data byte completing during W_REQ/W_DRAIN; issued from W_IDLE next. Byte completing while skid is full: dropped, overflow_err=1, col still increments.
- oled_res_n low (synced): clears col, page, skip, bit counter, shift register, display_on, skid; in-flight W_REQ completes its handshake. overflow_err not cleared.
- rst_n low: everything cleared, FSM to W_IDLE.

## Timing

- Reset values: fb_we=0, fb_w_xpos=0, fb_w_ypos=0, fb_din=0, cmd_valid=0, cmd_byte=0, display_on=0, overflow_err=0.
- Let E = first clk edge sampling spi_sclk high for bit 8. cmd_valid / byte latch at E+SYNC_STAGES+1; fb_we rises at E+SYNC_STAGES+2 when FSM idle.
- fb_we falls on the edge after fb_w_data_valid is sampled high; xpos/ypos/din unchanged while fb_we=1.
- Command decode effective for the next completed byte (no same-cycle hazard).
- cs_n rising on the same cycle as bit 8 edge: byte completes, then counter clears.

## Test plan

- Reset: hold rst_n=0 2 cycles with SPI idle → all outputs 0, no fb_we for 100 cycles.
- Commands 0xB3, 0x15, 0x02, data 0xA5 (acknowledge after 3 cycles) → one write x=82, y=24, din=0xA5; next data byte writes x=83.
- Set col 127, page 0, send data 0x01, 0x02 → writes x=127 then x=0, both y=0.
- Commands 0x81, 0xB7, then data 0xFF → 0xB7 skipped as contrast argument; write at y=0; cmd_valid pulses twice.
- 5 bits then cs_n high, then full byte 0xAF (DC=0) → no stray byte; display_on=1; cmd_byte=0xAF.
- fb_w_data_valid held 0, send data 0x11, 0x22, 0x33 → fb_we holds 0x11, 0x22 skidded, 0x33 dropped, overflow_err=1; release ack → writes 0x11 then 0x22 at consecutive columns, third column skipped.

Source files
------------

// File: rtl/ssd1309_spi_receiver.sv
// SSD1309 4-wire SPI receiver: oversamples the serial link, decodes the page-addressing
// command subset and converts pixel data bytes into framebuffer write handshakes.
module ssd1309_spi_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_sdin,
  input  logic       spi_dc,
  input  logic       spi_cs_n,
  input  logic       oled_res_n,
  output logic       fb_we,
  output logic [7:0] fb_w_xpos,
  output logic [7:0] fb_w_ypos,
  output logic [7:0] fb_din,
  input  logic       fb_w_data_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       display_on,
  output logic       overflow_err
);

  localparam int unsigned NSYNC = 5;
  // Synchronizer lane order {res_n, cs_n, dc, sdin, sclk}; idle values keep the link deselected
  localparam logic [NSYNC-1:0] SYNC_IDLE = 5'b01000;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] din;
  } wr_t;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DRAIN} wstate_t;

  logic [SYNC_STAGES-1:0][NSYNC-1:0] sync_q;
  logic sclk_s, sdin_s, dc_s, csn_s, res_s;
  logic sclk_d, csn_d;
  logic sclk_rise, bit_ok;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_rdy;
  logic [7:0] byte_q;
  logic       dc_q;

  logic [7:0] col, col_next;
  logic [2:0] page;
  logic [1:0] skip;
  wr_t        skid;
  logic       skid_valid;

  wstate_t state, state_next;
  logic    issue;

  assign {res_s, csn_s, dc_s, sdin_s, sclk_s} = sync_q[SYNC_STAGES-1];

  // Input synchronizers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{SYNC_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {oled_res_n, spi_cs_n, spi_dc, spi_sdin, spi_sclk}};
    end
  end

  // A rise coinciding with cs_n going high still counts, so a final bit is not lost
  assign sclk_rise = sclk_s & ~sclk_d;
  assign bit_ok    = sclk_rise & (~csn_s | ~csn_d);

  // Bit assembly, MSB first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_d   <= 1'b0;
      csn_d    <= 1'b1;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      byte_rdy <= 1'b0;
      byte_q   <= 8'd0;
      dc_q     <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      csn_d    <= csn_s;
      byte_rdy <= 1'b0;
      if (!res_s) begin
        bit_cnt <= 3'd0;
        shreg   <= 7'd0;
      end else if (bit_ok) begin
        if (bit_cnt == 3'd7) begin
          byte_q   <= {shreg, sdin_s};
          dc_q     <= dc_s;
          byte_rdy <= 1'b1;
          bit_cnt  <= 3'd0;
          shreg    <= 7'd0;
        end else if (csn_s) begin
          bit_cnt <= 3'd0;
          shreg   <= 7'd0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= {shreg[5:0], sdin_s};
        end
      end else if (csn_s) begin
        bit_cnt <= 3'd0;
        shreg   <= 7'd0;
      end
    end
  end

  assign col_next = (col == 8'(COLS - 1)) ? 8'd0 : col + 8'd1;

  // Command decode and data-byte capture into the skid slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'd0;
      display_on   <= 1'b0;
      overflow_err <= 1'b0;
      col          <= 8'd0;
      page         <= 3'd0;
      skip         <= 2'd0;
      skid         <= '0;
      skid_valid   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (issue) skid_valid <= 1'b0;
      if (!res_s) begin
        col        <= 8'd0;
        page       <= 3'd0;
        skip       <= 2'd0;
        display_on <= 1'b0;
        skid_valid <= 1'b0;
      end else if (byte_rdy) begin
        if (!dc_q) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= byte_q;
          if (skip != 2'd0) begin
            skip <= skip - 2'd1;
          end else begin
            case (byte_q) inside
              8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hFD: skip <= 2'd1;
              8'h21, 8'h22:   skip <= 2'd2;
              [8'h00:8'h0F]:  col[3:0] <= byte_q[3:0];
              [8'h10:8'h17]:  col[6:4] <= byte_q[2:0];
              [8'hB0:8'hB7]: begin
                if (32'(byte_q[2:0]) < PAGES) page <= byte_q[2:0];
              end
              8'hAE:          display_on <= 1'b0;
              8'hAF:          display_on <= 1'b1;
              default:        ;
            endcase
          end
        end else begin
          if (!skid_valid) begin
            skid       <= '{x: col, y: {2'b00, page, 3'b000}, din: byte_q};
            skid_valid <= 1'b1;
          end else begin
            overflow_err <= 1'b1;
          end
          col <= col_next;
        end
      end
    end
  end

  // Write handshake state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= W_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      W_IDLE:  if (skid_valid && res_s && !fb_w_data_valid) state_next = W_REQ;
      W_REQ:   if (fb_w_data_valid) state_next = W_DRAIN;
      W_DRAIN: if (!fb_w_data_valid) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  assign issue = (state == W_IDLE) && (state_next == W_REQ);

  // Registered write port; payload only changes when a new request starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_we     <= 1'b0;
      fb_w_xpos <= 8'd0;
      fb_w_ypos <= 8'd0;
      fb_din    <= 8'd0;
    end else begin
      fb_we <= (state_next == W_REQ);
      if (issue) begin
        fb_w_xpos <= skid.x;
        fb_w_ypos <= skid.y;
        fb_din    <= skid.din;
      end
    end
  end

endmodule

// File: tb/tb_ssd1309_spi_receiver.sv
// Directed bench for ssd1309_spi_receiver: SPI byte driver, acknowledging framebuffer
// responder and a queue of expected writes checked as each request appears.
module tb_ssd1309_spi_receiver;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] din;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, spi_sclk, spi_sdin, spi_dc, spi_cs_n, oled_res_n;
  logic fb_w_data_valid = 1'b0;
  logic fb_we, cmd_valid, display_on, overflow_err;
  logic [7:0] fb_w_xpos, fb_w_ypos, fb_din, cmd_byte;

  int tests = 0;
  int fails = 0;
  int writes_seen = 0;
  int cmd_pulses = 0;
  int ack_cnt = 0;
  int ack_delay = 3;
  int c0;
  bit ack_hold = 1'b0;
  bit in_req = 1'b0;
  wr_t cur, exp_w;
  wr_t exp_q[$];

  ssd1309_spi_receiver #(.SYNC_STAGES(2), .COLS(128), .PAGES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_sdin(spi_sdin), .spi_dc(spi_dc), .spi_cs_n(spi_cs_n),
    .oled_res_n(oled_res_n),
    .fb_we(fb_we), .fb_w_xpos(fb_w_xpos), .fb_w_ypos(fb_w_ypos), .fb_din(fb_din),
    .fb_w_data_valid(fb_w_data_valid),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .display_on(display_on), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer responder: scoreboard each new request, hold-check payload, acknowledge
  always @(negedge clk) begin
    if (cmd_valid) cmd_pulses++;
    if (fb_we) begin
      if (!in_req) begin
        in_req = 1'b1;
        ack_cnt = 0;
        cur = {fb_w_xpos, fb_w_ypos, fb_din};
        writes_seen++;
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("write_x", fb_w_xpos, exp_w.x);
          check("write_y", fb_w_ypos, exp_w.y);
          check("write_din", fb_din, exp_w.din);
        end
      end else begin
        check("write_stable", {fb_w_xpos, fb_w_ypos, fb_din}, cur);
      end
      if (!ack_hold && !fb_w_data_valid) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) fb_w_data_valid = 1'b1;
      end
    end else begin
      in_req = 1'b0;
      fb_w_data_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    spi_cs_n = 1'b0;
    spi_dc   = dc;
    for (int i = 7; i > 7 - n; i--) begin
      spi_sdin = b[i];
      spi_sclk = 1'b0;
      tick(3);
      spi_sclk = 1'b1;
      tick(3);
    end
    spi_sclk = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
  endtask

  task automatic wait_writes(input int n);
    int guard = 0;
    while (!(writes_seen >= n && !fb_we && !fb_w_data_valid) && guard < 2000) begin
      tick(1);
      guard++;
    end
    check("write_count", writes_seen, n);
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; spi_sclk = 1'b0; spi_sdin = 1'b0; spi_dc = 1'b0;
    spi_cs_n = 1'b1; oled_res_n = 1'b1;
    tick(2);
    check("rst_fb_we", fb_we, 0);
    check("rst_xpos", fb_w_xpos, 0);
    check("rst_ypos", fb_w_ypos, 0);
    check("rst_din", fb_din, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_display_on", display_on, 0);
    check("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;
    tick(100);
    check("idle_no_write", writes_seen, 0);
    check("idle_fb_we", fb_we, 0);

    // page 3, column 0x52, then two data bytes
    send_byte(8'hB3, 1'b0);
    send_byte(8'h15, 1'b0);
    send_byte(8'h02, 1'b0);
    tick(8);
    check("cmd_byte_02", cmd_byte, 8'h02);
    check("cmd_pulses_3", cmd_pulses, 3);
    exp_q.push_back('{x: 8'd82, y: 8'd24, din: 8'hA5});
    send_byte(8'hA5, 1'b1);
    wait_writes(1);
    exp_q.push_back('{x: 8'd83, y: 8'd24, din: 8'h5A});
    send_byte(8'h5A, 1'b1);
    wait_writes(2);

    // column wrap at 127
    send_byte(8'h0F, 1'b0);
    send_byte(8'h17, 1'b0);
    send_byte(8'hB0, 1'b0);
    exp_q.push_back('{x: 8'd127, y: 8'd0, din: 8'h01});
    send_byte(8'h01, 1'b1);
    exp_q.push_back('{x: 8'd0, y: 8'd0, din: 8'h02});
    send_byte(8'h02, 1'b1);
    wait_writes(4);

    // 0xB7 consumed as the contrast argument
    c0 = cmd_pulses;
    send_byte(8'h81, 1'b0);
    send_byte(8'hB7, 1'b0);
    tick(8);
    check("arg_cmd_pulses", cmd_pulses - c0, 2);
    exp_q.push_back('{x: 8'd1, y: 8'd0, din: 8'hFF});
    send_byte(8'hFF, 1'b1);
    wait_writes(5);

    // partial byte aborted by cs_n, then display on
    c0 = cmd_pulses;
    send_bits(8'hFF, 1'b0, 5);
    spi_cs_n = 1'b1;
    tick(8);
    send_byte(8'hAF, 1'b0);
    tick(8);
    check("partial_cmd_pulses", cmd_pulses - c0, 1);
    check("display_on_af", display_on, 1);
    check("cmd_byte_af", cmd_byte, 8'hAF);

    // stalled acknowledge: one in flight, one skidded, one dropped
    ack_hold = 1'b1;
    exp_q.push_back('{x: 8'd2, y: 8'd0, din: 8'h11});
    exp_q.push_back('{x: 8'd3, y: 8'd0, din: 8'h22});
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    tick(8);
    check("stall_fb_we", fb_we, 1);
    check("stall_din", fb_din, 8'h11);
    check("overflow_set", overflow_err, 1);
    check("stall_writes", writes_seen, 6);
    ack_hold = 1'b0;
    wait_writes(7);
    exp_q.push_back('{x: 8'd5, y: 8'd0, din: 8'h44});
    send_byte(8'h44, 1'b1);
    wait_writes(8);

    // display reset clears addressing and display_on, keeps overflow_err
    oled_res_n = 1'b0;
    tick(6);
    oled_res_n = 1'b1;
    tick(6);
    check("res_display_off", display_on, 0);
    check("res_overflow_kept", overflow_err, 1);
    exp_q.push_back('{x: 8'd0, y: 8'd0, din: 8'h55});
    send_byte(8'h55, 1'b1);
    wait_writes(9);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
